sync_up_counter: RTL

SYNC_UP_COUNTER -- requirements
Module: sync_up_counter

---
 rtl/sync_up_counter_pkg.sv | 22 ++
 rtl/sync_up_counter_tog_cell.sv | 33 +++
 rtl/sync_up_counter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/sync_up_counter_pkg.sv
// ============================================================================
// Module      : sync_up_counter_pkg
// Description : Shared state encoding and default sizing for sync_up_counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sync_up_counter_pkg;

    // Controller states; the encoding is fixed so it can be probed externally
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int C_DEFAULT_WIDTH = 4;
    localparam int C_DEFAULT_MAX   = 15;

endpackage : sync_up_counter_pkg

`default_nettype wire

// File: rtl/sync_up_counter_tog_cell.sv
// ============================================================================
// Module      : tog_cell
// Description : Single toggle flip-flop with asynchronous active-high reset.
//               The output inverts on a rising clk edge when t_i is high.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tog_cell
    import sync_up_counter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic t_i,
    output logic q_o
);

    logic q_q;

    // Toggle storage: clear on reset, invert when enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= 1'b0;
        end else if (t_i) begin
            q_q <= ~q_q;
        end
    end

    assign q_o = q_q;

endmodule : tog_cell

`default_nettype wire

// File: rtl/sync_up_counter.sv
// ============================================================================
// Module      : sync_up_counter
// Description : Modulo-(MAX+1) up counter with IDLE/RUN/DONE control, one-shot
//               or free-running mode, synchronous clear and load. Each count
//               bit is a tog_cell; this level computes the toggle enables.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_up_counter
    import sync_up_counter_pkg::*;
#(
    parameter int WIDTH = C_DEFAULT_WIDTH,
    parameter int MAX   = C_DEFAULT_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             stop,
    input  logic             oneshot,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             done,
    output logic             busy
);

    localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MAX);

    state_t           state_q;
    state_t           state_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             done_q;
    logic             busy_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             w_inc;
    logic [WIDTH-1:0] w_carry;
    logic [WIDTH-1:0] w_tog;
    logic             w_at_max;

    assign w_at_max = (count_q == C_MAX);

    // Next-state and next-count decode, priority clr > load > stop > start > increment
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wrap_d  = 1'b0;
        w_inc   = 1'b0;
        if (clr) begin
            count_d = '0;
            state_d = ST_IDLE;
        end else if (load) begin
            count_d = (load_val > C_MAX) ? C_MAX : load_val;
            // Loading below terminal count re-arms a finished one-shot
            if ((state_q == ST_DONE) && (count_d < C_MAX)) begin
                state_d = ST_RUN;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_d = ST_IDLE;
                    end else if (en) begin
                        if (!w_at_max) begin
                            count_d = count_q + WIDTH'(1);
                            w_inc   = 1'b1;
                        end else if (oneshot) begin
                            state_d = ST_DONE;
                        end else begin
                            count_d = '0;
                            wrap_d  = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        count_d = '0;
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Per-bit toggle enables: ripple-carry pattern for a plain increment,
    // otherwise toggle exactly the bits that differ from the target value
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i == 0) begin : g_lsb
            assign w_carry[i] = 1'b1;
        end else begin : g_upper
            assign w_carry[i] = &count_q[i-1:0];
        end

        assign w_tog[i] = w_inc ? w_carry[i] : (count_q[i] ^ count_d[i]);

        tog_cell u_tog (
            .clk (clk),
            .rst (rst),
            .t_i (w_tog[i]),
            .q_o (count_q[i])
        );
    end

    // Controller state and registered status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wrap_q  <= wrap_d;
            done_q  <= (state_d == ST_DONE);
            busy_q  <= (state_d == ST_RUN);
        end
    end

    assign count = count_q;
    assign tc    = w_at_max;
    assign wrap  = wrap_q;
    assign done  = done_q;
    assign busy  = busy_q;

endmodule : sync_up_counter

`default_nettype wire
